// File: rtl/srambank_pkg.sv
// srambank_pkg
//   Shared constants and types for the srambank request controller.
//   - SRAMBANK_AW / SRAMBANK_DW / SRAMBANK_RSP_DEPTH : default bank geometry
//     and response FIFO depth.
//   - state_t : controller state (ST_INIT exists only when SRAMBANK_INIT_EN
//     is defined at build time).
//   - req_t   : one request as seen on the upstream interface.
package srambank_pkg;

  localparam int SRAMBANK_AW        = 10;
  localparam int SRAMBANK_DW        = 80;
  localparam int SRAMBANK_RSP_DEPTH = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [SRAMBANK_AW-1:0] addr;
    logic [SRAMBANK_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/srambank_rsp_fifo.sv
// srambank_rsp_fifo
//   Synchronous response FIFO holding captured bank read data.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset (empties FIFO)
//     push, push_data     : write one entry
//     pop                 : consume head entry (ignored when empty)
//     pop_data            : head entry, valid whenever empty == 0
//     empty               : no entries stored
//     count               : number of entries stored (0..DEPTH)
//   Push and pop in the same cycle are allowed, including when full.
//   A push while full without a pop is a design error and is flagged by an
//   assertion; upstream credit accounting must prevent it.
module srambank_rsp_fifo
  import srambank_pkg::*;
#(
  parameter int DW    = SRAMBANK_DW,
  parameter int DEPTH = SRAMBANK_RSP_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      assert (!(push && full && !pop))
        else $error("srambank_rsp_fifo: push while full");
    end
  end

  // Storage carries no reset; entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/srambank_req_ctrl.sv
// srambank_req_ctrl
//   Request front-end for one synchronous SRAM bank (2**AW words x DW bits).
//   Registers the bank command pins, tracks the one-cycle bank read latency
//   and captures read data into a response FIFO.
//
//   Optional build macro: SRAMBANK_INIT_EN -- when defined, every reset is
//   followed by an INIT phase that writes zero to every bank word, one word
//   per cycle, before requests are accepted.
//
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     req_valid/req_ready        : request handshake
//     req_write/req_addr/req_wdata : request payload
//     rsp_valid/rsp_ready        : response handshake
//     rsp_data                   : read data, in read-acceptance order
//     busy                       : not accepting requests (reset or INIT)
//     ADDRESS/wd/banksel/read/write : registered bank command pins
//     dataout                    : bank read data, valid the cycle after a read
//
//   Handshake rule (both interfaces): a transfer happens on a rising edge
//   where valid and ready are both high; valid never depends on ready, and
//   req_ready never depends on req_valid or req_write.
//
//   Pipeline: handshake at edge N loads the command registers; the bank
//   performs the access at N+1 (pend_rd follows cmd_rd); at N+2 a read's
//   dataout is pushed into the FIFO. Requests are only accepted while
//   cmd_rd + pend_rd + fifo count < RSP_DEPTH, so every in-flight read has
//   a FIFO slot reserved and the bank is never stalled mid-read.
module srambank_req_ctrl
  import srambank_pkg::*;
#(
  parameter int AW        = SRAMBANK_AW,
  parameter int DW        = SRAMBANK_DW,
  parameter int RSP_DEPTH = SRAMBANK_RSP_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] wd,
  output logic          banksel,
  output logic          read,
  output logic          write,
  input  logic [DW-1:0] dataout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;

  state_t        state_q;
  state_t        state_d;
  logic          cmd_rd_q;
  logic          cmd_rd_d;
  logic          pend_rd_q;
  logic          banksel_d;
  logic          read_d;
  logic          write_d;
  logic [AW-1:0] address_d;
  logic [DW-1:0] wd_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [OW-1:0] outstanding;
  logic          req_fire;
  logic          rsp_fire;

`ifdef SRAMBANK_INIT_EN
  logic [AW-1:0] init_cnt_q;
  logic [AW-1:0] init_cnt_d;
`endif

  // Reads not yet delivered: in the command stage, at the bank, or queued.
  // A pop in the same cycle is deliberately not credited back.
  assign outstanding = OW'(cmd_rd_q) + OW'(pend_rd_q) + OW'(fifo_count);
  assign req_ready   = ~reset & (state_q == ST_RUN) & (outstanding < OW'(RSP_DEPTH));
  assign busy        = reset | (state_q != ST_RUN);
  assign req_fire    = req_valid & req_ready;
  assign rsp_valid   = ~fifo_empty;
  assign rsp_fire    = rsp_valid & rsp_ready;

  // Next-state and next-command logic.
  always_comb begin
    state_d   = state_q;
    banksel_d = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    address_d = ADDRESS;
    wd_d      = wd;
    cmd_rd_d  = 1'b0;
`ifdef SRAMBANK_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (req_fire) begin
          banksel_d = 1'b1;
          read_d    = ~req_write;
          write_d   = req_write;
          address_d = req_addr;
          cmd_rd_d  = ~req_write;
          // Write-data pins only change on writes.
          if (req_write) wd_d = req_wdata;
        end
      end
`ifdef SRAMBANK_INIT_EN
      ST_INIT: begin
        banksel_d  = 1'b1;
        write_d    = 1'b1;
        address_d  = init_cnt_q;
        wd_d       = '0;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SRAMBANK_INIT_EN
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
`else
      state_q    <= ST_RUN;
`endif
      banksel   <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;
      ADDRESS   <= '0;
      wd        <= '0;
      cmd_rd_q  <= 1'b0;
      pend_rd_q <= 1'b0;
    end else begin
`ifdef SRAMBANK_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      state_q   <= state_d;
      banksel   <= banksel_d;
      read      <= read_d;
      write     <= write_d;
      ADDRESS   <= address_d;
      wd        <= wd_d;
      cmd_rd_q  <= cmd_rd_d;
      pend_rd_q <= cmd_rd_q;
    end
  end

  // dataout is only sampled in the cycle after the bank performed a read.
  srambank_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_rd_q),
    .push_data (dataout),
    .pop       (rsp_fire),
    .pop_data  (rsp_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
